// File: rtl/mopshub_selftest_pkg.sv
// Shared types and defaults for the MOPSHUB self-test sequencer.
package mopshub_selftest_pkg;

    typedef logic [3:0] state_t;

    localparam state_t ST_IDLE    = 4'd0;
    localparam state_t ST_SELECT  = 4'd1;
    localparam state_t ST_RX_RUN  = 4'd2;
    localparam state_t ST_ENDWAIT = 4'd3;
    localparam state_t ST_GAP     = 4'd4;
    localparam state_t ST_TX_RUN  = 4'd5;
    localparam state_t ST_ADV_RUN = 4'd6;
    localparam state_t ST_NEXT    = 4'd7;
    localparam state_t ST_DONE    = 4'd8;

    typedef enum logic [1:0] {
        MODE_RX   = 2'd0,
        MODE_TX   = 2'd1,
        MODE_RXTX = 2'd2,
        MODE_ADV  = 2'd3
    } mode_t;

    localparam int unsigned GAP_CYCLES_DEF     = 120;
    localparam int unsigned TIMEOUT_CYCLES_DEF = 65535;

endpackage

// File: rtl/mopshub_selftest_seq_if.sv
// Request/end-strobe handshake between the sequencer and the bus test engines.
interface mopshub_selftest_seq_if;
    logic test_rx;
    logic test_rx_end;
    logic test_tx;
    logic test_tx_end;
    logic test_adv;
    logic test_adv_end;
    logic endwait_all;

    modport master (
        output test_rx, test_tx, test_adv, endwait_all,
        input  test_rx_end, test_tx_end, test_adv_end
    );

    modport slave (
        input  test_rx, test_tx, test_adv, endwait_all,
        output test_rx_end, test_tx_end, test_adv_end
    );
endinterface

// File: rtl/selftest_phase_timer.sv
// Loadable down-counter; expire_c is high while the count sits at zero.
module selftest_phase_timer #(
    parameter int unsigned W = 16
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         load,
    input  logic [W-1:0] load_val,
    output logic         expire_c
);

    logic [W-1:0] cnt;

    always_ff @(posedge clk) begin
        if (rst)
            cnt <= '0;
        else if (load)
            cnt <= load_val;
        else if (cnt != '0)
            cnt <= cnt - W'(1);
    end

    assign expire_c = (cnt == '0);

endmodule

// File: rtl/mopshub_selftest_seq.sv
// Self-test sequencer: sweeps the CAN bus array and runs RX/TX/advanced test
// phases against the bus engines with masking, gap, timeouts and bookkeeping.
module mopshub_selftest_seq
    import mopshub_selftest_pkg::*;
#(
    parameter int unsigned N_BUSES        = 32,
    parameter int unsigned BUS_W          = $clog2(N_BUSES),
    parameter int unsigned GAP_CYCLES     = GAP_CYCLES_DEF,
    parameter int unsigned TIMEOUT_CYCLES = TIMEOUT_CYCLES_DEF,
    parameter int unsigned CNT_W          = 16
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               start,
    input  logic               abort,
    input  logic [1:0]         mode,
    input  logic [BUS_W-1:0]   n_buses,
    input  logic [N_BUSES-1:0] bus_mask,
    input  logic               loop_en,
    mopshub_selftest_seq_if.master eng,
    output logic [BUS_W-1:0]   bus_id,
    output logic               busy,
    output logic               done,
    output logic               err_timeout,
    output logic [N_BUSES-1:0] fail_mask,
    output logic [CNT_W-1:0]   pass_cnt,
    output logic [CNT_W-1:0]   fail_cnt
);

    localparam int unsigned TMR_MAX = (GAP_CYCLES > TIMEOUT_CYCLES) ? GAP_CYCLES : TIMEOUT_CYCLES;
    localparam int unsigned TMR_W   = $clog2(TMR_MAX + 1);

    state_t             state, state_d;
    logic [BUS_W-1:0]   idx_d;
    mode_t              mode_q, mode_d;
    logic [BUS_W-1:0]   last_q, last_d;
    logic [N_BUSES-1:0] mask_q, mask_d;
    logic [N_BUSES-1:0] fmask_d;
    logic [CNT_W-1:0]   pass_d, fail_d;
    logic               err_d;
    logic               tmr_load;
    logic [TMR_W-1:0]   tmr_val;
    logic               tmr_expire_c;

    // Timer reloads on every state change: gap length in GAP, timeout otherwise.
    selftest_phase_timer #(.W(TMR_W)) u_timer (
        .clk      (clk),
        .rst      (rst),
        .load     (tmr_load),
        .load_val (tmr_val),
        .expire_c (tmr_expire_c)
    );

    assign tmr_load = (state_d != state);
    assign tmr_val  = (state_d == ST_GAP) ? TMR_W'(GAP_CYCLES - 1)
                                          : TMR_W'(TIMEOUT_CYCLES - 2);

    always_comb begin
        state_d = state;
        idx_d   = bus_id;
        mode_d  = mode_q;
        last_d  = last_q;
        mask_d  = mask_q;
        fmask_d = fail_mask;
        pass_d  = pass_cnt;
        fail_d  = fail_cnt;
        err_d   = 1'b0;

        if (abort) begin
            state_d = ST_IDLE;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (start) begin
                        mode_d  = mode_t'(mode);
                        last_d  = (32'(n_buses) > N_BUSES - 1) ? BUS_W'(N_BUSES - 1) : n_buses;
                        mask_d  = bus_mask;
                        fmask_d = '0;
                        pass_d  = '0;
                        fail_d  = '0;
                        idx_d   = '0;
                        state_d = ST_SELECT;
                    end
                end
                ST_SELECT: begin
                    if (mask_q[bus_id]) begin
                        state_d = ST_NEXT;
                    end else begin
                        case (mode_q)
                            MODE_TX:  state_d = ST_TX_RUN;
                            MODE_ADV: state_d = ST_ADV_RUN;
                            default:  state_d = ST_RX_RUN;
                        endcase
                    end
                end
                ST_RX_RUN: begin
                    if (eng.test_rx_end) begin
                        state_d = ST_ENDWAIT;
                    end else if (tmr_expire_c) begin
                        fmask_d[bus_id] = 1'b1;
                        err_d           = 1'b1;
                        state_d         = ST_NEXT;
                    end
                end
                ST_ENDWAIT: begin
                    state_d = (mode_q == MODE_RXTX) ? ST_GAP : ST_NEXT;
                end
                ST_GAP: begin
                    if (tmr_expire_c)
                        state_d = ST_TX_RUN;
                end
                ST_TX_RUN, ST_ADV_RUN: begin
                    if ((state == ST_TX_RUN) ? eng.test_tx_end : eng.test_adv_end) begin
                        state_d = ST_NEXT;
                    end else if (tmr_expire_c) begin
                        fmask_d[bus_id] = 1'b1;
                        err_d           = 1'b1;
                        state_d         = ST_NEXT;
                    end
                end
                ST_NEXT: begin
                    // Masked buses are visited but not counted.
                    if (!mask_q[bus_id]) begin
                        if (!fail_mask[bus_id]) begin
                            if (pass_cnt != {CNT_W{1'b1}})
                                pass_d = pass_cnt + CNT_W'(1);
                        end else begin
                            if (fail_cnt != {CNT_W{1'b1}})
                                fail_d = fail_cnt + CNT_W'(1);
                        end
                    end
                    if (bus_id < last_q) begin
                        idx_d   = bus_id + BUS_W'(1);
                        state_d = ST_SELECT;
                    end else if (loop_en) begin
                        idx_d   = '0;
                        state_d = ST_SELECT;
                    end else begin
                        state_d = ST_DONE;
                    end
                end
                ST_DONE: begin
                    state_d = ST_IDLE;
                end
                default: begin
                    state_d = ST_IDLE;
                end
            endcase
        end
    end

    // Outputs are registered from the next state so they align with state entry.
    always_ff @(posedge clk) begin
        if (rst) begin
            state           <= ST_IDLE;
            bus_id          <= '0;
            mode_q          <= MODE_RX;
            last_q          <= '0;
            mask_q          <= '0;
            fail_mask       <= '0;
            pass_cnt        <= '0;
            fail_cnt        <= '0;
            err_timeout     <= 1'b0;
            done            <= 1'b0;
            busy            <= 1'b0;
            eng.test_rx     <= 1'b0;
            eng.test_tx     <= 1'b0;
            eng.test_adv    <= 1'b0;
            eng.endwait_all <= 1'b0;
        end else begin
            state           <= state_d;
            bus_id          <= idx_d;
            mode_q          <= mode_d;
            last_q          <= last_d;
            mask_q          <= mask_d;
            fail_mask       <= fmask_d;
            pass_cnt        <= pass_d;
            fail_cnt        <= fail_d;
            err_timeout     <= err_d;
            done            <= (state_d == ST_DONE);
            busy            <= (state_d != ST_IDLE) && (state_d != ST_DONE);
            eng.test_rx     <= (state_d == ST_RX_RUN);
            eng.test_tx     <= (state_d == ST_TX_RUN);
            eng.test_adv    <= (state_d == ST_ADV_RUN);
            eng.endwait_all <= (state_d == ST_ENDWAIT);
        end
    end

endmodule

// File: tb/tb_mopshub_selftest_seq.sv
// Directed bench for mopshub_selftest_seq: table of sweeps plus hand-written
// loop/abort, timeout and reset-during-gap sequences.
module tb_mopshub_selftest_seq;
    import mopshub_selftest_pkg::*;

    localparam int NB  = 16;
    localparam int GAP = 120;
    localparam int TMO = 200;
    localparam int LAT = 50;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst, start, abort, loop_en;
    logic [1:0]  mode;
    logic [3:0]  n_buses;
    logic [15:0] bus_mask;
    logic [3:0]  bus_id;
    logic        busy, done, err_timeout;
    logic [15:0] fail_mask, pass_cnt, fail_cnt;
    logic        eng_rx_end, eng_tx_end, eng_adv_end, stray_rx;
    logic [15:0] silent;

    mopshub_selftest_seq_if eng();
    assign eng.test_rx_end  = eng_rx_end | stray_rx;
    assign eng.test_tx_end  = eng_tx_end;
    assign eng.test_adv_end = eng_adv_end;

    mopshub_selftest_seq #(
        .N_BUSES(NB), .GAP_CYCLES(GAP), .TIMEOUT_CYCLES(TMO), .CNT_W(16)
    ) dut (
        .clk(clk), .rst(rst), .start(start), .abort(abort), .mode(mode),
        .n_buses(n_buses), .bus_mask(bus_mask), .loop_en(loop_en), .eng(eng),
        .bus_id(bus_id), .busy(busy), .done(done), .err_timeout(err_timeout),
        .fail_mask(fail_mask), .pass_cnt(pass_cnt), .fail_cnt(fail_cnt)
    );

    int cyc = 0;
    initial forever begin @(posedge clk); cyc++; end

    // Engine model: each request answered LAT cycles after it rises; silent buses never end RX.
    int rx_c = 0, tx_c = 0, adv_c = 0;
    initial begin
        eng_rx_end = 1'b0; eng_tx_end = 1'b0; eng_adv_end = 1'b0;
        forever begin
            @(posedge clk); #1;
            rx_c  = eng.test_rx  ? rx_c + 1  : 0;
            tx_c  = eng.test_tx  ? tx_c + 1  : 0;
            adv_c = eng.test_adv ? adv_c + 1 : 0;
            eng_rx_end  = eng.test_rx && (rx_c == LAT) && !silent[bus_id];
            eng_tx_end  = eng.test_tx && (tx_c == LAT);
            eng_adv_end = eng.test_adv && (adv_c == LAT);
        end
    end

    logic        mon_clr = 1'b0;
    logic        prx = 1'b0, ptx = 1'b0, padv = 1'b0;
    int          n_rx, n_tx, n_adv, n_ew, n_done, n_err;
    int          rx_rise, ew_cyc, gap_last, err_rel, done_cyc;
    logic [15:0] tested;
    int          adv_seq[$];

    initial forever begin
        @(negedge clk);
        if (mon_clr) begin
            n_rx = 0; n_tx = 0; n_adv = 0; n_ew = 0; n_done = 0; n_err = 0;
            rx_rise = 0; ew_cyc = 0; gap_last = -1; err_rel = -1; done_cyc = -1;
            tested = '0;
            adv_seq.delete();
        end else begin
            if (eng.test_rx && !prx) begin n_rx++; tested[bus_id] = 1'b1; rx_rise = cyc; end
            if (eng.test_tx && !ptx) begin n_tx++; tested[bus_id] = 1'b1; gap_last = cyc - ew_cyc; end
            if (eng.test_adv && !padv) begin n_adv++; tested[bus_id] = 1'b1; adv_seq.push_back(int'(bus_id)); end
            if (eng.endwait_all) begin n_ew++; ew_cyc = cyc; end
            if (done) begin n_done++; done_cyc = cyc; end
            if (err_timeout) begin n_err++; err_rel = cyc - rx_rise; end
        end
        prx = eng.test_rx; ptx = eng.test_tx; padv = eng.test_adv;
    end

    int n_chk = 0, n_fail = 0;

    task automatic chk(input string name, input int act, input int exp);
        n_chk++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk); #2;
    endtask

    task automatic mon_clear();
        mon_clr = 1'b1; tick(); mon_clr = 1'b0;
    endtask

    task automatic launch(input logic [1:0] m, input int nb, input logic [15:0] msk, output int sc);
        mon_clear();
        mode = m; n_buses = 4'(nb); bus_mask = msk; start = 1'b1; sc = cyc;
        tick();
        start = 1'b0;
    endtask

    task automatic wait_done(input string name);
        int k = 0;
        while (n_done == 0 && k < 20000) begin tick(); k++; end
        n_chk++;
        if (n_done == 0) begin
            n_fail++;
            $display("FAIL %s: no done within budget, got 0 pulses, expected 1", name);
        end
        repeat (3) tick();
    endtask

    task automatic chk_zero_outputs(input string tag);
        chk({tag, "_test_rx"}, int'(eng.test_rx), 0);
        chk({tag, "_test_tx"}, int'(eng.test_tx), 0);
        chk({tag, "_test_adv"}, int'(eng.test_adv), 0);
        chk({tag, "_endwait"}, int'(eng.endwait_all), 0);
        chk({tag, "_busy"}, int'(busy), 0);
        chk({tag, "_done"}, int'(done), 0);
        chk({tag, "_err"}, int'(err_timeout), 0);
        chk({tag, "_bus_id"}, int'(bus_id), 0);
        chk({tag, "_fail_mask"}, int'(fail_mask), 0);
        chk({tag, "_pass_cnt"}, int'(pass_cnt), 0);
        chk({tag, "_fail_cnt"}, int'(fail_cnt), 0);
    endtask

    typedef struct {
        logic [1:0]  mode;
        int          nb;
        logic [15:0] mask;
        logic [15:0] silent;
        int          pass;
        int          fail;
        logic [15:0] fmask;
        int          rx;
        int          tx;
        int          adv;
        int          ew;
        int          err;
        logic [15:0] tested;
        int          done_rel;
    } vec_t;

    vec_t vt[6];

    initial begin
        int sc, k;
        int exp_seq[5];

        vt[0] = '{2'(MODE_RXTX), 3,  16'h0000, 16'h0000, 4, 0, 16'h0000, 4, 4, 0, 4, 0, 16'h000F, 0};
        vt[1] = '{2'(MODE_RX),   3,  16'h0005, 16'h0000, 2, 0, 16'h0000, 2, 0, 0, 2, 0, 16'h000A, 0};
        vt[2] = '{2'(MODE_RXTX), 3,  16'h0000, 16'h0004, 3, 1, 16'h0004, 4, 3, 0, 3, 1, 16'h000F, 0};
        vt[3] = '{2'(MODE_TX),   2,  16'h0002, 16'h0000, 2, 0, 16'h0000, 0, 2, 0, 0, 0, 16'h0005, 0};
        vt[4] = '{2'(MODE_ADV),  1,  16'h0000, 16'h0000, 2, 0, 16'h0000, 0, 0, 2, 0, 0, 16'h0003, 0};
        vt[5] = '{2'(MODE_RX),   15, 16'hFFFF, 16'h0000, 0, 0, 16'h0000, 0, 0, 0, 0, 0, 16'h0000, 33};
        exp_seq = '{0, 1, 0, 1, 0};

        rst = 1'b1; start = 1'b0; abort = 1'b0; loop_en = 1'b0; mode = 2'd0;
        n_buses = 4'd0; bus_mask = '0; silent = '0; stray_rx = 1'b0;
        repeat (3) tick();
        chk_zero_outputs("reset");
        rst = 1'b0;
        tick();

        for (int i = 0; i < 6; i++) begin
            silent = vt[i].silent;
            launch(vt[i].mode, vt[i].nb, vt[i].mask, sc);
            wait_done($sformatf("v%0d_done_wait", i));
            chk($sformatf("v%0d_pass_cnt", i), int'(pass_cnt), vt[i].pass);
            chk($sformatf("v%0d_fail_cnt", i), int'(fail_cnt), vt[i].fail);
            chk($sformatf("v%0d_fail_mask", i), int'(fail_mask), int'(vt[i].fmask));
            chk($sformatf("v%0d_rx_reqs", i), n_rx, vt[i].rx);
            chk($sformatf("v%0d_tx_reqs", i), n_tx, vt[i].tx);
            chk($sformatf("v%0d_adv_reqs", i), n_adv, vt[i].adv);
            chk($sformatf("v%0d_endwaits", i), n_ew, vt[i].ew);
            chk($sformatf("v%0d_timeouts", i), n_err, vt[i].err);
            chk($sformatf("v%0d_done_pulses", i), n_done, 1);
            chk($sformatf("v%0d_tested", i), int'(tested), int'(vt[i].tested));
            chk($sformatf("v%0d_busy_after", i), int'(busy), 0);
            if (vt[i].mode == 2'(MODE_RXTX))
                chk($sformatf("v%0d_gap", i), gap_last, GAP + 1);
            if (vt[i].err > 0)
                chk($sformatf("v%0d_timeout_cycle", i), err_rel, TMO - 1);
            if (vt[i].done_rel > 0)
                chk($sformatf("v%0d_done_latency", i), done_cyc - sc, vt[i].done_rel);
        end
        silent = '0;

        // Loop mode on two buses, then abort in the middle of an ADV phase.
        loop_en = 1'b1;
        launch(2'(MODE_ADV), 1, 16'h0000, sc);
        k = 0;
        while (adv_seq.size() < 5 && k < 3000) begin tick(); k++; end
        for (int i = 0; i < 5; i++)
            chk($sformatf("loop_bus_seq%0d", i), (adv_seq.size() > i) ? adv_seq[i] : -1, exp_seq[i]);
        chk("loop_pass_cnt", int'(pass_cnt), 4);
        repeat (10) tick();
        chk("loop_adv_before_abort", int'(eng.test_adv), 1);
        abort = 1'b1;
        tick();
        abort = 1'b0;
        chk("abort_adv_low", int'(eng.test_adv), 0);
        chk("abort_busy_low", int'(busy), 0);
        chk("abort_pass_kept", int'(pass_cnt), 4);
        chk("abort_fail_kept", int'(fail_cnt), 0);
        loop_en = 1'b0;
        repeat (60) tick();
        chk("abort_no_done", n_done, 0);
        chk("abort_stays_idle", int'(busy), 0);

        // abort and start together: abort wins.
        mon_clear();
        mode = 2'(MODE_ADV); n_buses = 4'd0; bus_mask = '0;
        abort = 1'b1; start = 1'b1;
        tick();
        abort = 1'b0; start = 1'b0;
        chk("abort_start_busy", int'(busy), 0);
        tick();
        chk("abort_start_no_req", int'(eng.test_adv), 0);
        chk("abort_start_pass_kept", int'(pass_cnt), 4);

        // Reset during GAP, then restart with a stray RX end strobe.
        launch(2'(MODE_RXTX), 0, 16'h0000, sc);
        k = 0;
        while (n_ew == 0 && k < 1000) begin tick(); k++; end
        repeat (10) tick();
        chk("gap_busy", int'(busy), 1);
        chk("gap_tx_low", int'(eng.test_tx), 0);
        mon_clear();
        rst = 1'b1;
        tick();
        chk_zero_outputs("midgap_rst");
        rst = 1'b0; start = 1'b1; stray_rx = 1'b1;
        mode = 2'(MODE_RXTX); n_buses = 4'd0; bus_mask = '0;
        tick();
        start = 1'b0; stray_rx = 1'b0;
        chk("restart_select_rx", int'(eng.test_rx), 0);
        chk("restart_select_busy", int'(busy), 1);
        tick();
        chk("restart_rx_rise", int'(eng.test_rx), 1);
        chk("restart_bus_id", int'(bus_id), 0);
        tick();
        chk("restart_rx_held", int'(eng.test_rx), 1);
        start = 1'b1;
        tick();
        start = 1'b0;
        chk("start_while_busy_ignored", int'(eng.test_rx), 1);
        wait_done("restart_done_wait");
        chk("restart_pass_cnt", int'(pass_cnt), 1);
        chk("restart_endwaits", n_ew, 1);
        chk("restart_tx_reqs", n_tx, 1);
        chk("restart_timeouts", n_err, 0);
        chk("restart_done_pulses", n_done, 1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
